// File: rtl/p2s_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per enabled clock with first/last framing flags.
module p2s_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    logic             r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;

    logic             w_shifting;
    logic             w_last;
    logic             w_accept;
    logic             w_head;
    logic [WIDTH-1:0] w_sreg_next;

    assign w_shifting = (r_state == S_SHIFT);
    assign w_last     = w_shifting && (r_cnt == LAST_IDX);
    // Ready while idle, or on the final enabled bit so words stream without a gap.
    assign in_ready   = !w_shifting || (w_last && en);
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_head      = r_sreg[0];
        w_sreg_next = r_sreg >> 1;
        if (MSB_FIRST) begin
            w_head      = r_sreg[WIDTH-1];
            w_sreg_next = r_sreg << 1;
        end
    end

    assign out_valid = w_shifting;
    assign out_bit   = w_shifting && w_head;
    assign out_first = w_shifting && (r_cnt == '0);
    assign out_last  = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= S_SHIFT;
            r_sreg  <= in_data;
            r_cnt   <= '0;
        end else if (w_shifting && en) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_sreg <= w_sreg_next;
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_p2s_serializer.sv
// Scoreboard bench for p2s_serializer: stimulus pushes hand-computed bit sequences,
// per-instance monitors pop and compare whenever out_valid & en is presented.
module tb_p2s_serializer;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       en8 = 1'b1, v8 = 1'b0;
    logic [7:0] data8 = '0;
    logic       rdy8, bit8, val8, first8, last8;

    logic       en1 = 1'b1, v1 = 1'b0;
    logic [0:0] data1 = '0;
    logic       rdy1, bit1, val1, first1, last1;

    logic       en4 = 1'b1, v4 = 1'b0;
    logic [3:0] data4 = '0;
    logic       rdy4, bit4, val4, first4, last4;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q4[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    p2s_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_d8 (
        .clk(clk), .rst(rst), .en(en8), .in_data(data8), .in_valid(v8),
        .in_ready(rdy8), .out_bit(bit8), .out_valid(val8),
        .out_first(first8), .out_last(last8)
    );

    p2s_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) u_d1 (
        .clk(clk), .rst(rst), .en(en1), .in_data(data1), .in_valid(v1),
        .in_ready(rdy1), .out_bit(bit1), .out_valid(val1),
        .out_first(first1), .out_last(last1)
    );

    p2s_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_d4 (
        .clk(clk), .rst(rst), .en(en4), .in_data(data4), .in_valid(v4),
        .in_ready(rdy4), .out_bit(bit4), .out_valid(val4),
        .out_first(first4), .out_last(last4)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[7] is the first bit expected on the wire; only the first n bits are queued.
    task automatic push8(input logic [7:0] seq, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b = seq[7-i];
            e.f = (i == 0);
            e.l = (i == 7);
            q8.push_back(e);
        end
    endtask

    task automatic push4(input logic [3:0] seq);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.b = seq[3-i];
            e.f = (i == 0);
            e.l = (i == 3);
            q4.push_back(e);
        end
    endtask

    task automatic push1(input logic b);
        exp_t e;
        e.b = b;
        e.f = 1'b1;
        e.l = 1'b1;
        q1.push_back(e);
    endtask

    task automatic idle_check8(input string name);
        @(negedge clk);
        check({name, "_valid"}, {31'd0, val8}, 32'd0);
        check({name, "_drained"}, q8.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && val8 && en8) begin
            if (q8.size() == 0) begin
                check("d8_unexpected_bit", 32'd1, 32'd0);
            end else begin
                check("d8_sb", {29'd0, bit8, first8, last8}, {29'd0, q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && val1 && en1) begin
            if (q1.size() == 0) begin
                check("d1_unexpected_bit", 32'd1, 32'd0);
            end else begin
                check("d1_sb", {29'd0, bit1, first1, last1}, {29'd0, q1.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && val4 && en4) begin
            if (q4.size() == 0) begin
                check("d4_unexpected_bit", 32'd1, 32'd0);
            end else begin
                check("d4_sb", {29'd0, bit4, first4, last4}, {29'd0, q4.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a word offered: nothing may load.
        v8 = 1'b1;
        data8 = 8'hA5;
        repeat (2) tick();
        @(negedge clk);
        check("rst_valid", {31'd0, val8}, 32'd0);
        check("rst_bit", {31'd0, bit8}, 32'd0);
        check("rst_ready", {31'd0, rdy8}, 32'd1);
        check("rst_first_last", {30'd0, first8, last8}, 32'd0);
        tick();
        rst = 1'b0;
        v8 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_no_load", {31'd0, val8}, 32'd0);
            tick();
        end

        // Single word 8'hB4, LSB first: 0,0,1,0,1,1,0,1
        data8 = 8'hB4;
        v8 = 1'b1;
        push8(8'b0010_1101, 8);
        tick();
        v8 = 1'b0;
        data8 = 8'h5A;
        repeat (8) tick();
        idle_check8("b4_idle");
        tick();

        // Stall: 8'h0F, en low for 3 cycles while the 4th bit (1) is shown.
        data8 = 8'h0F;
        v8 = 1'b1;
        push8(8'b1111_0000, 8);
        tick();
        v8 = 1'b0;
        repeat (3) tick();
        en8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_bit", {30'd0, val8, bit8}, 32'd3);
            check("stall_flags", {30'd0, first8, last8}, 32'd0);
            check("stall_ready", {31'd0, rdy8}, 32'd0);
            tick();
        end
        en8 = 1'b1;
        repeat (5) tick();
        idle_check8("stall_idle");
        tick();

        // Back-to-back 8'hFF then 8'h00 with in_valid held high.
        data8 = 8'hFF;
        v8 = 1'b1;
        push8(8'hFF, 8);
        tick();
        data8 = 8'h00;
        push8(8'h00, 8);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("b2b_ready", {31'd0, rdy8}, (i == 8) ? 32'd1 : 32'd0);
            tick();
        end
        v8 = 1'b0;
        @(negedge clk);
        check("b2b_first_cycle9", {30'd0, val8, first8}, 32'd3);
        repeat (8) tick();
        idle_check8("b2b_idle");
        tick();

        // Asynchronous reset during the 4th bit of 8'hFF.
        data8 = 8'hFF;
        v8 = 1'b1;
        push8(8'hFF, 3);
        tick();
        v8 = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, val8}, 32'd0);
        check("midrst_bit", {31'd0, bit8}, 32'd0);
        check("midrst_ready", {31'd0, rdy8}, 32'd1);
        check("midrst_drained", q8.size(), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        data8 = 8'h01;
        v8 = 1'b1;
        push8(8'b1000_0000, 8);
        tick();
        v8 = 1'b0;
        repeat (8) tick();
        idle_check8("after_rst_idle");
        tick();

        // WIDTH=1: two words back-to-back, each flagged first and last.
        data1 = 1'b1;
        v1 = 1'b1;
        push1(1'b1);
        tick();
        data1 = 1'b0;
        push1(1'b0);
        @(negedge clk);
        check("w1_flags", {29'd0, val1, first1, last1}, 32'd7);
        check("w1_ready", {31'd0, rdy1}, 32'd1);
        tick();
        v1 = 1'b0;
        @(negedge clk);
        check("w1_flags_2nd", {29'd0, val1, first1, last1}, 32'd7);
        tick();
        @(negedge clk);
        check("w1_idle", {31'd0, val1}, 32'd0);
        check("w1_drained", q1.size(), 32'd0);
        tick();

        // WIDTH=4 MSB first: 4'b1000 -> 1,0,0,0 then 4'b0110 -> 0,1,1,0 back-to-back.
        data4 = 4'b1000;
        v4 = 1'b1;
        push4(4'b1000);
        tick();
        data4 = 4'b0110;
        push4(4'b0110);
        repeat (4) tick();
        v4 = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("w4_idle", {31'd0, val4}, 32'd0);
        check("w4_drained", q4.size(), 32'd0);
        check("d8_final_drained", q8.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
